exec_arbiter: RTL and testbench
===============================

Name: exec_arbiter

Overview:
- Shares the single execute stage (ALU + condition codes) between two requesters: port 0 is the main pipeline, port 1 is the debug/microcode port.
- Round-robin grant and a valid/ready accept handshake on each request port.
- Drives the execute unit's icode/ifun/valA/valB/valC for a programmable number of cycles, then captures valE/Cnd into a held response.
- One operation is outstanding at a time.

Parameters:
- DATA_W, 64: operand/result width.
- EX_LAT, 1: cycles operands are held on the execute inputs before valE/Cnd are sampled. Legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- req0_valid_i  in  1  requester 0 has an operation.
- req0_ready_o  out  1  requester 0 accepted this cycle.
- req0_icode_i, req0_ifun_i  in  4 each  instruction code and function code.
- req0_valA_i, req0_valB_i, req0_valC_i  in  DATA_W each  operands.
- req1_valid_i, req1_ready_o, req1_icode_i, req1_ifun_i, req1_valA_i, req1_valB_i, req1_valC_i: same as the req0 ports, for requester 1.
- ex_icode_o, ex_ifun_o  out  4 each  to the execute unit.
- ex_valA_o, ex_valB_o, ex_valC_o  out  DATA_W each  to the execute unit.
- ex_valE_i  in  DATA_W  execute result.
- ex_Cnd_i  in  1  execute condition result.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_id_o  out  1  requester that owns the response.
- rsp_valE_o  out  DATA_W  captured valE.
- rsp_Cnd_o  out  1  captured Cnd.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - state=IDLE, rr_ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_valE_o=0, rsp_Cnd_o=0.
  - ex_icode_o=`INOP, ex_ifun_o=0, ex_valA_o/ex_valB_o/ex_valC_o=0.
  - Reset mid-operation discards the operation; no response is ever produced for it.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - The grant is combinational from the valid inputs and rr_ptr.
  - If only one valid is high, that requester is granted. If both are high, the requester indicated by rr_ptr is granted.
  - reqN_ready_o is high only in IDLE, only for the granted N, and only while reqN_valid_i is high. Both ready outputs are never high together.
  - On accept: register the operands and icode/ifun, grant_id=N, cnt=EX_LAT-1, next state ISSUE.
- ISSUE:
  - ex_* outputs are driven from the registered operands.
  - If cnt!=0: cnt decrements.
  - If cnt==0: rsp_valE_o<=ex_valE_i, rsp_Cnd_o<=ex_Cnd_i, rsp_id_o<=grant_id, rsp_valid_o<=1, ex_icode_o<=`INOP, next state RESP.
  - ISSUE lasts exactly EX_LAT cycles.
- RESP:
  - rsp_* outputs are held stable while rsp_ready_i is low.
  - On rsp_valid_o&rsp_ready_i: rsp_valid_o<=0, rr_ptr<=~grant_id, next state IDLE.
- Ready outputs are 0 in ISSUE and RESP; requesters hold their valid/payload until they are accepted.
- Latency: accept edge to rsp_valid_o high is EX_LAT+1 edges. Minimum repeat interval is EX_LAT+2 cycles.
- Requester payload changes while not accepted are don't-care; only the values at the accept edge are used.
- rr_ptr advances only on response completion, not on accept.
- ex_icode_o is `INOP whenever the state is not ISSUE, so CC is never disturbed while idle.

Optional Feature:
- Macro: EXEC_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid. rr_ptr is unused and stays 0. Requester 1 is granted only when req0_valid_i is low in IDLE.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single op: req0 valid, icode=`IOPQ, ifun=`FADDL, valA=3, valB=2, EX_LAT=1.
  -> req0_ready_o high in the first cycle; rsp_valid_o high 2 edges later; rsp_valE_o=5, rsp_id_o=0.
- Subtract and stall: req1 sends `FSUBL, valA=3, valB=2, with rsp_ready_i held low 5 cycles.
  -> rsp_valE_o=-1 (all ones), rsp_id_o=1, held stable for all 5 cycles; both ready outputs stay 0 until the handshake.
- Contention: both requesters continuously valid (`FANDL 3,2 and `FXORL 3,2), rsp_ready_i=1.
  -> responses alternate id 0,1,0,1 with valE 2,1,2,1; interval EX_LAT+2.
- Latency: EX_LAT=3, req0 `FADDL 3,2.
  -> ex_icode_o=`IOPQ for exactly 3 cycles; rsp_valid_o high 4 edges after accept; valE=5.
- Reset mid-ISSUE: rst_n_i low for one edge.
  -> next cycle state IDLE, rsp_valid_o=0, ex_icode_o=`INOP; a following simultaneous request grants req0.
- EXEC_ARB_FIXED_PRIO_EN defined, both requesters continuously valid.
  -> every response has rsp_id_o=0; req1_ready_o never asserted.

Source files
------------

// File: rtl/exec_arbiter.sv
// exec_arbiter: shares one execute stage (ALU + condition codes) between two
// requesters. Port 0 is the main pipeline, port 1 the debug/microcode port.
// Requests are granted round-robin and accepted with a valid/ready handshake.
// The accepted operation is driven onto the execute inputs for EX_LAT cycles.
// valE/Cnd are then captured into a response that is held until it is taken.
// Only one operation is outstanding at a time.
//
// Parameters:
//   DATA_W  operand/result width
//   EX_LAT  cycles the operands sit on the execute inputs (1..15)
//
// Ports:
//   clk_i, rst_n_i              clock (rising edge), synchronous active-low reset
//   reqN_valid_i/reqN_ready_o   request handshake for requester N (0/1)
//   reqN_icode_i/reqN_ifun_i    instruction/function code of the request
//   reqN_valA_i/valB_i/valC_i   request operands
//   ex_icode_o..ex_valC_o       operation presented to the execute unit
//   ex_valE_i, ex_Cnd_i         execute unit result and condition
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_id_o                    requester that owns the response
//   rsp_valE_o, rsp_Cnd_o       captured result and condition
//
// Build option:
//   EXEC_ARB_FIXED_PRIO_EN  requester 0 always wins when both are valid.
//                           The round-robin pointer is not built.

`ifndef INOP
`define INOP 4'h1
`endif

module exec_arbiter #(
  parameter int DATA_W = 64,
  parameter int EX_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [3:0]        req0_icode_i,
  input  logic [3:0]        req0_ifun_i,
  input  logic [DATA_W-1:0] req0_valA_i,
  input  logic [DATA_W-1:0] req0_valB_i,
  input  logic [DATA_W-1:0] req0_valC_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [3:0]        req1_icode_i,
  input  logic [3:0]        req1_ifun_i,
  input  logic [DATA_W-1:0] req1_valA_i,
  input  logic [DATA_W-1:0] req1_valB_i,
  input  logic [DATA_W-1:0] req1_valC_i,
  output logic [3:0]        ex_icode_o,
  output logic [3:0]        ex_ifun_o,
  output logic [DATA_W-1:0] ex_valA_o,
  output logic [DATA_W-1:0] ex_valB_o,
  output logic [DATA_W-1:0] ex_valC_o,
  input  logic [DATA_W-1:0] ex_valE_i,
  input  logic              ex_Cnd_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_valE_o,
  output logic              rsp_Cnd_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // The counter is loaded with EX_LAT-1 so the ISSUE state lasts EX_LAT cycles.
  localparam logic [3:0] CNT_INIT = 4'(EX_LAT - 1);

  state_t state_r, state_s;
  logic              grant_s, accept_s, ready0_s, ready1_s;
  logic              grant_id_r;
  logic [3:0]        cnt_r;
  logic [3:0]        ex_icode_r, ex_ifun_r;
  logic [DATA_W-1:0] ex_valA_r, ex_valB_r, ex_valC_r;
  logic              rsp_valid_r, rsp_id_r, rsp_Cnd_r;
  logic [DATA_W-1:0] rsp_valE_r;
`ifndef EXEC_ARB_FIXED_PRIO_EN
  logic              rr_ptr_r;
`endif

  // Grant selection, ready generation and next-state logic
  always_comb begin
    state_s  = state_r;
    grant_s  = 1'b0;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    accept_s = 1'b0;
`ifdef EXEC_ARB_FIXED_PRIO_EN
    // Requester 1 only wins when requester 0 is not asking.
    grant_s = req1_valid_i & ~req0_valid_i;
`else
    if (req0_valid_i && req1_valid_i) begin
      grant_s = rr_ptr_r;
    end else if (req1_valid_i) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`endif
    case (state_r)
      IDLE: begin
        ready0_s = ~grant_s & req0_valid_i;
        ready1_s = grant_s & req1_valid_i;
        accept_s = ready0_s | ready1_s;
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: begin
        if (rsp_valid_r && rsp_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, latency counter, response capture and pointer update
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant_id_r  <= 1'b0;
      cnt_r       <= 4'd0;
      ex_icode_r  <= `INOP;
      ex_ifun_r   <= 4'd0;
      ex_valA_r   <= {DATA_W{1'b0}};
      ex_valB_r   <= {DATA_W{1'b0}};
      ex_valC_r   <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_valE_r  <= {DATA_W{1'b0}};
      rsp_Cnd_r   <= 1'b0;
`ifndef EXEC_ARB_FIXED_PRIO_EN
      rr_ptr_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            grant_id_r <= grant_s;
            cnt_r      <= CNT_INIT;
            if (grant_s) begin
              ex_icode_r <= req1_icode_i;
              ex_ifun_r  <= req1_ifun_i;
              ex_valA_r  <= req1_valA_i;
              ex_valB_r  <= req1_valB_i;
              ex_valC_r  <= req1_valC_i;
            end else begin
              ex_icode_r <= req0_icode_i;
              ex_ifun_r  <= req0_ifun_i;
              ex_valA_r  <= req0_valA_i;
              ex_valB_r  <= req0_valB_i;
              ex_valC_r  <= req0_valC_i;
            end
          end
        end
        ISSUE: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            rsp_valE_r  <= ex_valE_i;
            rsp_Cnd_r   <= ex_Cnd_i;
            rsp_id_r    <= grant_id_r;
            rsp_valid_r <= 1'b1;
            // Park the execute unit so condition codes are not disturbed.
            ex_icode_r  <= `INOP;
          end
        end
        RESP: begin
          if (rsp_valid_r && rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
`ifndef EXEC_ARB_FIXED_PRIO_EN
            // The pointer moves on completion only, favouring the other port.
            rr_ptr_r    <= ~grant_id_r;
`endif
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready_o = ready0_s;
  assign req1_ready_o = ready1_s;
  assign ex_icode_o   = ex_icode_r;
  assign ex_ifun_o    = ex_ifun_r;
  assign ex_valA_o    = ex_valA_r;
  assign ex_valB_o    = ex_valB_r;
  assign ex_valC_o    = ex_valC_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_id_o     = rsp_id_r;
  assign rsp_valE_o   = rsp_valE_r;
  assign rsp_Cnd_o    = rsp_Cnd_r;

endmodule

// File: tb/tb_exec_arbiter.sv
// Testbench for exec_arbiter. Instance dut uses EX_LAT=1 and instance dut3
// uses EX_LAT=3. A small ALU model acts as the execute unit. Expected
// responses are queued when requests are driven and are checked on arrival.
module tb_exec_arbiter;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IOPQ  = 4'h6;
  localparam logic [3:0] FADDL = 4'h0;
  localparam logic [3:0] FSUBL = 4'h1;
  localparam logic [3:0] FANDL = 4'h2;
  localparam logic [3:0] FXORL = 4'h3;

  typedef struct packed {
    logic        id;
    logic [63:0] valE;
    logic        cnd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0]  r0_icode, r0_ifun, r1_icode, r1_ifun;
  logic [63:0] r0_valA, r0_valB, r0_valC, r1_valA, r1_valB, r1_valC;

  logic [3:0]  ex_icode, ex_ifun;
  logic [63:0] ex_valA, ex_valB, ex_valC, ex_valE;
  logic        ex_Cnd;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_Cnd;
  logic [63:0] rsp_valE;

  logic        b_valid0, b_valid1, b_ready0, b_ready1;
  logic [3:0]  b_ex_icode, b_ex_ifun;
  logic [63:0] b_ex_valA, b_ex_valB, b_ex_valC, b_ex_valE;
  logic        b_ex_Cnd;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_Cnd;
  logic [63:0] b_rsp_valE;

  always #5 clk = ~clk;

  // Execute unit model: OPq computes valB op valA; Cnd mirrors the sign flag.
  function automatic logic [63:0] alu(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [63:0] a, input logic [63:0] b);
    if (ic != IOPQ) return 64'hBAD0_BAD0_BAD0_BAD0;
    case (fn)
      FADDL:   return b + a;
      FSUBL:   return b - a;
      FANDL:   return b & a;
      FXORL:   return b ^ a;
      default: return 64'd0;
    endcase
  endfunction

  assign ex_valE   = alu(ex_icode, ex_ifun, ex_valA, ex_valB);
  assign ex_Cnd    = ex_valE[63];
  assign b_ex_valE = alu(b_ex_icode, b_ex_ifun, b_ex_valA, b_ex_valB);
  assign b_ex_Cnd  = b_ex_valE[63];

  exec_arbiter #(.DATA_W(64), .EX_LAT(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(r0_valid), .req0_ready_o(r0_ready),
    .req0_icode_i(r0_icode), .req0_ifun_i(r0_ifun),
    .req0_valA_i(r0_valA), .req0_valB_i(r0_valB), .req0_valC_i(r0_valC),
    .req1_valid_i(r1_valid), .req1_ready_o(r1_ready),
    .req1_icode_i(r1_icode), .req1_ifun_i(r1_ifun),
    .req1_valA_i(r1_valA), .req1_valB_i(r1_valB), .req1_valC_i(r1_valC),
    .ex_icode_o(ex_icode), .ex_ifun_o(ex_ifun),
    .ex_valA_o(ex_valA), .ex_valB_o(ex_valB), .ex_valC_o(ex_valC),
    .ex_valE_i(ex_valE), .ex_Cnd_i(ex_Cnd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_valE_o(rsp_valE), .rsp_Cnd_o(rsp_Cnd)
  );

  exec_arbiter #(.DATA_W(64), .EX_LAT(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(b_valid0), .req0_ready_o(b_ready0),
    .req0_icode_i(r0_icode), .req0_ifun_i(r0_ifun),
    .req0_valA_i(r0_valA), .req0_valB_i(r0_valB), .req0_valC_i(r0_valC),
    .req1_valid_i(b_valid1), .req1_ready_o(b_ready1),
    .req1_icode_i(r1_icode), .req1_ifun_i(r1_ifun),
    .req1_valA_i(r1_valA), .req1_valB_i(r1_valB), .req1_valC_i(r1_valC),
    .ex_icode_o(b_ex_icode), .ex_ifun_o(b_ex_ifun),
    .ex_valA_o(b_ex_valA), .ex_valB_o(b_ex_valB), .ex_valC_o(b_ex_valC),
    .ex_valE_i(b_ex_valE), .ex_Cnd_i(b_ex_Cnd),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_id_o(b_rsp_id),
    .rsp_valE_o(b_rsp_valE), .rsp_Cnd_o(b_rsp_Cnd)
  );

  // Wait up to budget negedges for rsp_valid; waited is -1 on timeout.
  task automatic wait_rsp(input int budget, output int waited);
    waited = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        waited = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_id !== 1'b0 || rsp_Cnd !== 1'b0 || rsp_valE !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_data: got id=%b cnd=%b valE=%h expected 0/0/0", rsp_id, rsp_Cnd, rsp_valE); end
    n_checks++; if (ex_icode !== INOP || ex_ifun !== 4'd0) begin n_fail++; $display("FAIL reset_ex_code: got %h/%h expected %h/0", ex_icode, ex_ifun, INOP); end
    n_checks++; if (ex_valA !== 64'd0 || ex_valB !== 64'd0 || ex_valC !== 64'd0) begin n_fail++; $display("FAIL reset_ex_vals: got %h %h %h expected 0", ex_valA, ex_valB, ex_valC); end
    n_checks++; if (b_rsp_valid !== 1'b0 || b_ex_icode !== INOP) begin n_fail++; $display("FAIL reset_dut3: got valid=%b icode=%h expected 0/%h", b_rsp_valid, b_ex_icode, INOP); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    exp_t e;
    @(negedge clk);
    rsp_ready = 1'b1;
    r0_icode = IOPQ; r0_ifun = FADDL; r0_valA = 64'd3; r0_valB = 64'd2; r0_valC = 64'd7;
    r0_valid = 1'b1;
    e.id = 1'b0; e.valE = 64'd5; e.cnd = 1'b0;
    sb_q.push_back(e);
    #1;
    n_checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got r0=%b r1=%b expected 1/0", r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 1'b0;
    n_checks++; if (ex_icode !== IOPQ || ex_ifun !== FADDL || ex_valA !== 64'd3 || ex_valB !== 64'd2 || ex_valC !== 64'd7) begin n_fail++; $display("FAIL single_ex_drive: got %h %h %h %h %h expected 6 0 3 2 7", ex_icode, ex_ifun, ex_valA, ex_valB, ex_valC); end
    n_checks++; if (rsp_valid !== 1'b0 || r0_ready !== 1'b0) begin n_fail++; $display("FAIL single_early: got rsp_valid=%b ready=%b expected 0/0", rsp_valid, r0_ready); end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: got rsp_valid=%b expected 1", rsp_valid);
    end else begin
      e = sb_q.pop_front();
      n_checks++; if (rsp_id !== e.id || rsp_valE !== e.valE || rsp_Cnd !== e.cnd) begin n_fail++; $display("FAIL single_rsp: got id=%b valE=%h cnd=%b expected %b/%h/%b", rsp_id, rsp_valE, rsp_Cnd, e.id, e.valE, e.cnd); end
    end
    n_checks++; if (ex_icode !== INOP) begin n_fail++; $display("FAIL single_inop: got %h expected %h", ex_icode, INOP); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_sub_stall();
    exp_t e;
    int w;
    @(negedge clk);
    rsp_ready = 1'b0;
    r1_icode = IOPQ; r1_ifun = FSUBL; r1_valA = 64'd3; r1_valB = 64'd2; r1_valC = 64'd0;
    r1_valid = 1'b1;
    e.id = 1'b1; e.valE = {64{1'b1}}; e.cnd = 1'b1;
    sb_q.push_back(e);
    #1;
    n_checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin n_fail++; $display("FAIL sub_ready: got r0=%b r1=%b expected 0/1", r0_ready, r1_ready); end
    @(negedge clk);
    r1_valid = 1'b0;
    wait_rsp(8, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL sub_latency: got %0d expected 1", w); end
    if (w > 0) begin
      e = sb_q.pop_front();
      // Offer new work while stalled; nothing may be accepted.
      r0_icode = IOPQ; r0_ifun = FANDL; r0_valA = 64'd3; r0_valB = 64'd2;
      r1_icode = IOPQ; r1_ifun = FXORL; r1_valA = 64'd3; r1_valB = 64'd2;
      r0_valid = 1'b1; r1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        #1;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_valE !== e.valE || rsp_Cnd !== e.cnd) begin n_fail++; $display("FAIL sub_hold cycle %0d: got v=%b id=%b valE=%h cnd=%b expected 1/%b/%h/%b", k, rsp_valid, rsp_id, rsp_valE, rsp_Cnd, e.id, e.valE, e.cnd); end
        n_checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL sub_ready_stall cycle %0d: got %b/%b expected 0/0", k, r0_ready, r1_ready); end
        @(negedge clk);
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sub_done: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_contention();
    exp_t e;
    int got = 0, last = 0;
    logic both_seen = 1'b0, r1_seen = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    r0_icode = IOPQ; r0_ifun = FANDL; r0_valA = 64'd3; r0_valB = 64'd2;
    r1_icode = IOPQ; r1_ifun = FXORL; r1_valA = 64'd3; r1_valB = 64'd2;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef EXEC_ARB_FIXED_PRIO_EN
      e.id = 1'b0;
`else
      e.id = (k % 2 == 1);
`endif
      e.valE = e.id ? 64'd1 : 64'd2;
      e.cnd = 1'b0;
      sb_q.push_back(e);
    end
    #1;
    if (r1_ready) r1_seen = 1'b1;
    if (r0_ready && r1_ready) both_seen = 1'b1;
    for (int c = 1; c <= 40 && got < 4; c++) begin
      @(negedge clk);
      if (r1_ready) r1_seen = 1'b1;
      if (r0_ready && r1_ready) both_seen = 1'b1;
      if (rsp_valid) begin
        e = sb_q.pop_front();
        n_checks++; if (rsp_id !== e.id || rsp_valE !== e.valE) begin n_fail++; $display("FAIL contention_rsp %0d: got id=%b valE=%h expected %b/%h", got, rsp_id, rsp_valE, e.id, e.valE); end
        n_checks++; if (c - last != ((got == 0) ? 2 : 3)) begin n_fail++; $display("FAIL contention_interval %0d: got %0d expected %0d", got, c - last, (got == 0) ? 2 : 3); end
        last = c;
        got++;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL contention_count: got %0d expected 4", got); end
    n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL contention_both_ready: got 1 expected 0"); end
`ifdef EXEC_ARB_FIXED_PRIO_EN
    n_checks++; if (r1_seen !== 1'b0) begin n_fail++; $display("FAIL fixed_r1_ready: got 1 expected 0"); end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    exp_t e;
    int icode_cycles = 0, first = -1;
    @(negedge clk);
    b_rsp_ready = 1'b1;
    r0_icode = IOPQ; r0_ifun = FADDL; r0_valA = 64'd3; r0_valB = 64'd2; r0_valC = 64'd0;
    b_valid0 = 1'b1;
    e.id = 1'b0; e.valE = 64'd5; e.cnd = 1'b0;
    sb_q.push_back(e);
    #1;
    n_checks++; if (b_ready0 !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %b expected 1", b_ready0); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      b_valid0 = 1'b0;
      if (b_ex_icode == IOPQ) icode_cycles++;
      if (b_rsp_valid && first < 0) begin
        first = i;
        e = sb_q.pop_front();
        n_checks++; if (b_rsp_valE !== e.valE || b_rsp_id !== e.id || b_rsp_Cnd !== e.cnd) begin n_fail++; $display("FAIL lat_rsp: got id=%b valE=%h cnd=%b expected %b/%h/%b", b_rsp_id, b_rsp_valE, b_rsp_Cnd, e.id, e.valE, e.cnd); end
      end
    end
    n_checks++; if (icode_cycles != 3) begin n_fail++; $display("FAIL lat_issue_cycles: got %0d expected 3", icode_cycles); end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL lat_rsp_edge: got %0d expected 4", first); end
    n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_done: got %b expected 0", b_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int w;
    @(negedge clk);
    rsp_ready = 1'b1;
    r1_icode = IOPQ; r1_ifun = FSUBL; r1_valA = 64'd3; r1_valB = 64'd2;
    r1_valid = 1'b1;
    #1;
    n_checks++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", r1_ready); end
    @(negedge clk);
    r1_valid = 1'b0;
    n_checks++; if (ex_icode !== IOPQ) begin n_fail++; $display("FAIL rmid_issue: got %h expected %h", ex_icode, IOPQ); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (rsp_valid !== 1'b0 || ex_icode !== INOP || ex_valA !== 64'd0) begin n_fail++; $display("FAIL rmid_after: got valid=%b icode=%h valA=%h expected 0/%h/0", rsp_valid, ex_icode, ex_valA, INOP); end
    r0_icode = IOPQ; r0_ifun = FADDL; r0_valA = 64'd3; r0_valB = 64'd2;
    r0_valid = 1'b1; r1_valid = 1'b1;
    e.id = 1'b0; e.valE = 64'd5; e.cnd = 1'b0;
    sb_q.push_back(e);
    #1;
    n_checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_grant: got r0=%b r1=%b expected 1/0", r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_rsp(6, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL rmid_latency: got %0d expected 1", w); end
    if (w > 0) begin
      e = sb_q.pop_front();
      n_checks++; if (rsp_id !== e.id || rsp_valE !== e.valE) begin n_fail++; $display("FAIL rmid_rsp: got id=%b valE=%h expected %b/%h", rsp_id, rsp_valE, e.id, e.valE); end
    end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    r0_valid = 1'b0; r1_valid = 1'b0; b_valid0 = 1'b0; b_valid1 = 1'b0;
    r0_icode = INOP; r0_ifun = 4'd0; r0_valA = 64'd0; r0_valB = 64'd0; r0_valC = 64'd0;
    r1_icode = INOP; r1_ifun = 4'd0; r1_valA = 64'd0; r1_valB = 64'd0; r1_valC = 64'd0;
    rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_sub_stall();
    test_contention();
    test_latency();
    test_reset_mid();
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
